// File: rtl/fetch_addr_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_addr_gen_pkg
//  Brief    : Bus constants, FSM state type and address helper for the
//             fetch address generator.
//  Revision : 1.0  initial release
// ============================================================================
package fetch_addr_gen_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        FAG_IDLE  = 2'd0,
        FAG_ISSUE = 2'd1,
        FAG_HOLD  = 2'd2
    } f_fag_state;

    // Halfword address A[31:1] -> next word, upper-half flag cleared
    function automatic logic [30:0] seq_next(input logic [30:0] a);
        return {a[30:1] + 30'd1, 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/seu_regs.sv
`default_nettype none
// ============================================================================
//  Module   : seu_regs
//  Brief    : Front-end state register bank with asynchronous active-low
//             reset to a parameterised value.
//  Revision : 1.0  initial release
// ============================================================================
module seu_regs #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic           s_clk_i,
    input  logic           s_resetn_i,
    input  logic [W-1:0]   s_d_i,
    output logic [W-1:0]   s_q_o
);

    logic [W-1:0] r_q;

    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            r_q <= RST_VAL;
        end else begin
            r_q <= s_d_i;
        end
    end

    assign s_q_o = r_q;

endmodule
`default_nettype wire

// File: rtl/fetch_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_addr_gen
//  Brief    : Fetch address generator: issues word-aligned AHB-lite fetches,
//             selects flush / RAS / sequential next address, kills stale data.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_addr_gen
    import fetch_addr_gen_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
    input  logic         s_clk_i,
    input  logic         s_resetn_i,
    input  logic         s_flush_i,
    input  logic [31:0]  s_flush_addr_i,
    input  logic         s_ifb_full_i,
    input  logic [1:0]   s_poped_i,
    input  logic [30:0]  s_pop_addr_i,
    input  logic         s_hready_i,
    output logic [31:0]  s_haddr_o,
    output logic [1:0]   s_htrans_o,
    output logic         s_valid_o,
    output logic [29:0]  s_fetch_addr_o,
    output logic         s_ualign_o,
    output logic         s_dvalid_o
);

    f_fag_state   r_state;
    logic [1:0]   r_state_q;
    logic [30:0]  r_addr;
    logic         r_redir_v;
    logic [30:0]  r_redir_addr;
    logic         r_boot;
    logic         r_pend;
    logic         r_kill;

    f_fag_state   w_state_nxt;
    logic [30:0]  w_addr_nxt;
    logic         w_redir_v_nxt;
    logic [30:0]  w_redir_addr_nxt;
    logic         w_pend_nxt;
    logic         w_kill_nxt;
    logic         w_accept;
    logic         w_pop_v;
    logic         w_unused;

    assign w_unused = s_flush_addr_i[0];
    assign r_state  = f_fag_state'(r_state_q);

    // Front-end register group 5
    seu_regs #(.W(2), .RST_VAL(FAG_IDLE)) u_state_reg (
        .s_clk_i(s_clk_i), .s_resetn_i(s_resetn_i),
        .s_d_i(w_state_nxt), .s_q_o(r_state_q)
    );

    seu_regs #(.W(31), .RST_VAL(BOOT_ADDR[31:1])) u_addr_reg (
        .s_clk_i(s_clk_i), .s_resetn_i(s_resetn_i),
        .s_d_i(w_addr_nxt), .s_q_o(r_addr)
    );

    seu_regs #(.W(32), .RST_VAL(32'd0)) u_redir_reg (
        .s_clk_i(s_clk_i), .s_resetn_i(s_resetn_i),
        .s_d_i({w_redir_v_nxt, w_redir_addr_nxt}), .s_q_o({r_redir_v, r_redir_addr})
    );

    seu_regs #(.W(3), .RST_VAL(3'b100)) u_flag_reg (
        .s_clk_i(s_clk_i), .s_resetn_i(s_resetn_i),
        .s_d_i({1'b0, w_pend_nxt, w_kill_nxt}), .s_q_o({r_boot, r_pend, r_kill})
    );

    assign w_accept = (r_state != FAG_IDLE) && s_hready_i;
    assign w_pop_v  = (s_poped_i != 2'b00) && !s_flush_i;

    always_comb begin
        w_state_nxt      = r_state;
        w_addr_nxt       = r_addr;
        w_redir_v_nxt    = r_redir_v;
        w_redir_addr_nxt = r_redir_addr;
        w_pend_nxt       = r_pend;
        w_kill_nxt       = r_kill;

        // Outstanding data phase completes on hready; a redirect while it waits kills it
        if (s_hready_i) begin
            w_pend_nxt = 1'b0;
            w_kill_nxt = 1'b0;
        end else if (r_pend && (s_flush_i || w_pop_v)) begin
            w_kill_nxt = 1'b1;
        end

        case (r_state)
            FAG_IDLE: begin
                if (r_boot || !s_ifb_full_i) begin
                    w_state_nxt = FAG_ISSUE;
                end
                if (s_flush_i) begin
                    w_addr_nxt = s_flush_addr_i[31:1];
                end else if (w_pop_v) begin
                    w_addr_nxt = s_pop_addr_i;
                end
            end
            default: begin
                if (s_hready_i) begin
                    w_state_nxt   = s_ifb_full_i ? FAG_IDLE : FAG_ISSUE;
                    w_pend_nxt    = 1'b1;
                    // The word just accepted is sequential; any redirect makes it stale
                    w_kill_nxt    = s_flush_i || r_redir_v || w_pop_v;
                    w_redir_v_nxt = 1'b0;
                    if (s_flush_i) begin
                        w_addr_nxt = s_flush_addr_i[31:1];
                    end else if (r_redir_v) begin
                        w_addr_nxt = r_redir_addr;
                    end else if (w_pop_v) begin
                        w_addr_nxt = s_pop_addr_i;
                    end else begin
                        w_addr_nxt = seq_next(r_addr);
                    end
                end else begin
                    // Address phase must stay stable; park the redirect
                    w_state_nxt = FAG_HOLD;
                    if (s_flush_i) begin
                        w_redir_v_nxt    = 1'b1;
                        w_redir_addr_nxt = s_flush_addr_i[31:1];
                    end else if (w_pop_v && !r_redir_v) begin
                        w_redir_v_nxt    = 1'b1;
                        w_redir_addr_nxt = s_pop_addr_i;
                    end
                end
            end
        endcase
    end

    assign s_haddr_o      = {r_addr[30:1], 2'b00};
    assign s_htrans_o     = (r_state == FAG_IDLE) ? HTRANS_IDLE : HTRANS_NONSEQ;
    assign s_valid_o      = w_accept && !s_flush_i;
    assign s_fetch_addr_o = r_addr[30:1];
    assign s_ualign_o     = s_valid_o && r_addr[0];
    assign s_dvalid_o     = r_pend && s_hready_i && !r_kill && !s_flush_i;

endmodule
`default_nettype wire

// File: tb/tb_fetch_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_addr_gen
//  Brief    : Self-checking bench: directed scenarios plus random traffic
//             against a queue-based behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_addr_gen;

    localparam logic [31:0] BOOT = 32'h0000_0080;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic [31:0]  faddr = 32'd0;
    logic         full = 1'b0;
    logic [1:0]   poped = 2'b00;
    logic [30:0]  paddr = 31'd0;
    logic         hready = 1'b1;

    logic [31:0]  s_haddr_o;
    logic [1:0]   s_htrans_o;
    logic         s_valid_o;
    logic [29:0]  s_fetch_addr_o;
    logic         s_ualign_o;
    logic         s_dvalid_o;

    int checks = 0;
    int errors = 0;

    fetch_addr_gen #(.BOOT_ADDR(BOOT)) dut (
        .s_clk_i(clk), .s_resetn_i(rst_n),
        .s_flush_i(flush), .s_flush_addr_i(faddr),
        .s_ifb_full_i(full), .s_poped_i(poped), .s_pop_addr_i(paddr),
        .s_hready_i(hready),
        .s_haddr_o(s_haddr_o), .s_htrans_o(s_htrans_o), .s_valid_o(s_valid_o),
        .s_fetch_addr_o(s_fetch_addr_o), .s_ualign_o(s_ualign_o), .s_dvalid_o(s_dvalid_o)
    );

    always #5 clk = ~clk;

    // Behavioural model: byte addresses, a redirect queue and a data-phase queue of kill bits
    bit           m_busy;
    bit           m_boot;
    logic [31:0]  m_addr;
    logic [31:0]  m_redir[$];
    bit           m_data[$];

    logic [31:0]  exp_haddr;
    logic [1:0]   exp_htrans;
    logic         exp_valid;
    logic [29:0]  exp_fetch;
    logic         exp_ualign;
    logic         exp_dvalid;

    task automatic model_reset();
        m_busy = 0;
        m_boot = 1;
        m_addr = BOOT & 32'hFFFF_FFFE;
        m_redir.delete();
        m_data.delete();
    endtask

    task automatic model_eval();
        bit acc;
        acc        = m_busy && hready;
        exp_haddr  = m_addr & 32'hFFFF_FFFC;
        exp_htrans = m_busy ? 2'b10 : 2'b00;
        exp_valid  = acc && !flush;
        exp_fetch  = m_addr[31:2];
        exp_ualign = exp_valid && m_addr[1];
        exp_dvalid = (m_data.size() != 0) && hready && !flush && !m_data[0];
    endtask

    task automatic model_tick();
        bit          acc;
        bit          popv;
        logic [31:0] pop_b;
        logic [31:0] fl_b;
        acc   = m_busy && hready;
        popv  = (poped != 2'b00) && !flush;
        pop_b = {paddr, 1'b0};
        fl_b  = faddr & 32'hFFFF_FFFE;
        if (m_data.size() != 0) begin
            if (hready) void'(m_data.pop_front());
            else if (flush || popv) m_data[0] = 1'b1;
        end
        if (acc) begin
            m_data.push_back(flush || (m_redir.size() != 0) || popv);
            if (flush) m_addr = fl_b;
            else if (m_redir.size() != 0) m_addr = m_redir[0];
            else if (popv) m_addr = pop_b;
            else m_addr = (m_addr & 32'hFFFF_FFFC) + 32'd4;
            m_redir.delete();
            m_busy = !full;
        end else if (m_busy) begin
            if (flush) begin
                m_redir.delete();
                m_redir.push_back(fl_b);
            end else if (popv && m_redir.size() == 0) begin
                m_redir.push_back(pop_b);
            end
        end else begin
            m_busy = m_boot || !full;
            if (flush) m_addr = fl_b;
            else if (popv) m_addr = pop_b;
        end
        m_boot = 0;
    endtask

    // One clock: model follows the edge, then new inputs are applied and settled
    task automatic cyc(input logic f, input logic [31:0] fa, input logic fu,
                       input logic [1:0] p, input logic [30:0] pa, input logic hr);
        @(posedge clk);
        model_tick();
        @(negedge clk);
        flush = f; faddr = fa; full = fu; poped = p; paddr = pa; hready = hr;
        #1;
        model_eval();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        flush = 0; faddr = 0; full = 0; poped = 0; paddr = 0; hready = 1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; hready = 1'b0;
        #1;
        checks++; if (s_haddr_o !== 32'h80) begin errors++; $display("FAIL reset_haddr got %h want %h", s_haddr_o, 32'h80); end
        checks++; if (s_htrans_o !== 2'b00) begin errors++; $display("FAIL reset_htrans got %b want 00", s_htrans_o); end
        checks++; if ({s_valid_o, s_ualign_o, s_dvalid_o} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {s_valid_o, s_ualign_o, s_dvalid_o}); end
        do_reset();
        checks++; if (s_htrans_o !== 2'b00) begin errors++; $display("FAIL release_idle got %b want 00", s_htrans_o); end
    endtask

    task automatic test_sequential();
        logic [31:0] a;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0, 1);
            a = 32'h80 + 32'(4 * i);
            checks++; if (s_haddr_o !== a || s_htrans_o !== 2'b10) begin errors++; $display("FAIL seq_bus[%0d] got %h/%b want %h/10", i, s_haddr_o, s_htrans_o, a); end
            checks++; if (s_valid_o !== 1'b1 || s_fetch_addr_o !== a[31:2]) begin errors++; $display("FAIL seq_fetch[%0d] got %b/%h want 1/%h", i, s_valid_o, s_fetch_addr_o, a[31:2]); end
            checks++; if (s_dvalid_o !== (i != 0)) begin errors++; $display("FAIL seq_dvalid[%0d] got %b want %b", i, s_dvalid_o, (i != 0)); end
        end
    endtask

    task automatic test_hold();
        do_reset();
        cyc(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0, 0);
            checks++; if (s_haddr_o !== 32'h84 || s_htrans_o !== 2'b10) begin errors++; $display("FAIL hold_bus[%0d] got %h/%b want 84/10", i, s_haddr_o, s_htrans_o); end
            checks++; if (s_valid_o !== 1'b0 || s_dvalid_o !== 1'b0) begin errors++; $display("FAIL hold_valid[%0d] got %b%b want 00", i, s_valid_o, s_dvalid_o); end
        end
        cyc(0, 0, 0, 0, 0, 1);
        checks++; if (s_haddr_o !== 32'h84 || s_valid_o !== 1'b1 || s_fetch_addr_o !== 30'h21) begin errors++; $display("FAIL hold_release got %h/%b/%h want 84/1/21", s_haddr_o, s_valid_o, s_fetch_addr_o); end
        checks++; if (s_dvalid_o !== 1'b1) begin errors++; $display("FAIL hold_data got %b want 1", s_dvalid_o); end
    endtask

    task automatic test_pop();
        do_reset();
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 2'b01, 31'h101, 1);
        checks++; if (s_haddr_o !== 32'h88 || s_valid_o !== 1'b1 || s_dvalid_o !== 1'b1) begin errors++; $display("FAIL pop_cycle got %h/%b/%b want 88/1/1", s_haddr_o, s_valid_o, s_dvalid_o); end
        cyc(0, 0, 0, 0, 0, 1);
        checks++; if (s_haddr_o !== 32'h200 || s_ualign_o !== 1'b1 || s_fetch_addr_o !== 30'h80) begin errors++; $display("FAIL pop_target got %h/%b/%h want 200/1/80", s_haddr_o, s_ualign_o, s_fetch_addr_o); end
        checks++; if (s_dvalid_o !== 1'b0) begin errors++; $display("FAIL pop_kill got %b want 0", s_dvalid_o); end
        cyc(0, 0, 0, 0, 0, 1);
        checks++; if (s_haddr_o !== 32'h204 || s_ualign_o !== 1'b0 || s_dvalid_o !== 1'b1) begin errors++; $display("FAIL pop_next got %h/%b/%b want 204/0/1", s_haddr_o, s_ualign_o, s_dvalid_o); end
    endtask

    task automatic test_flush_hold();
        do_reset();
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 32'h1000, 0, 0, 0, 0);
        checks++; if (s_haddr_o !== 32'h84 || s_valid_o !== 1'b0 || s_dvalid_o !== 1'b0) begin errors++; $display("FAIL fh_flush got %h/%b/%b want 84/0/0", s_haddr_o, s_valid_o, s_dvalid_o); end
        cyc(0, 0, 0, 0, 0, 0);
        checks++; if (s_haddr_o !== 32'h84) begin errors++; $display("FAIL fh_stable got %h want 84", s_haddr_o); end
        cyc(0, 0, 0, 0, 0, 1);
        checks++; if (s_haddr_o !== 32'h84 || s_valid_o !== 1'b1 || s_dvalid_o !== 1'b0) begin errors++; $display("FAIL fh_accept got %h/%b/%b want 84/1/0", s_haddr_o, s_valid_o, s_dvalid_o); end
        cyc(0, 0, 0, 0, 0, 1);
        checks++; if (s_haddr_o !== 32'h1000 || s_dvalid_o !== 1'b0) begin errors++; $display("FAIL fh_target got %h/%b want 1000/0", s_haddr_o, s_dvalid_o); end
        cyc(0, 0, 0, 0, 0, 1);
        checks++; if (s_haddr_o !== 32'h1004 || s_dvalid_o !== 1'b1) begin errors++; $display("FAIL fh_next got %h/%b want 1004/1", s_haddr_o, s_dvalid_o); end
    endtask

    task automatic test_flush_pop();
        do_reset();
        cyc(0, 0, 0, 0, 0, 1);
        cyc(1, 32'h400, 0, 2'b10, 31'h400, 1);
        checks++; if (s_valid_o !== 1'b0 || s_dvalid_o !== 1'b0) begin errors++; $display("FAIL fp_valid got %b%b want 00", s_valid_o, s_dvalid_o); end
        cyc(0, 0, 0, 0, 0, 1);
        checks++; if (s_haddr_o !== 32'h400 || s_dvalid_o !== 1'b0) begin errors++; $display("FAIL fp_target got %h/%b want 400/0", s_haddr_o, s_dvalid_o); end
        cyc(0, 0, 0, 0, 0, 1);
        checks++; if (s_haddr_o !== 32'h404 || s_dvalid_o !== 1'b1) begin errors++; $display("FAIL fp_next got %h/%b want 404/1", s_haddr_o, s_dvalid_o); end
    endtask

    task automatic test_ifb_full();
        do_reset();
        cyc(0, 0, 1, 0, 0, 1);
        checks++; if (s_haddr_o !== 32'h80 || s_valid_o !== 1'b1) begin errors++; $display("FAIL full_accept got %h/%b want 80/1", s_haddr_o, s_valid_o); end
        cyc(0, 0, 1, 0, 0, 1);
        checks++; if (s_htrans_o !== 2'b00 || s_valid_o !== 1'b0 || s_dvalid_o !== 1'b1) begin errors++; $display("FAIL full_idle got %b/%b/%b want 00/0/1", s_htrans_o, s_valid_o, s_dvalid_o); end
        cyc(0, 0, 0, 0, 0, 1);
        checks++; if (s_htrans_o !== 2'b00) begin errors++; $display("FAIL full_still_idle got %b want 00", s_htrans_o); end
        cyc(0, 0, 0, 0, 0, 1);
        checks++; if (s_htrans_o !== 2'b10 || s_haddr_o !== 32'h84 || s_fetch_addr_o !== 30'h21) begin errors++; $display("FAIL full_resume got %b/%h/%h want 10/84/21", s_htrans_o, s_haddr_o, s_fetch_addr_o); end
    endtask

    task automatic test_wrap();
        do_reset();
        cyc(1, 32'hFFFF_FFFD, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        checks++; if (s_haddr_o !== 32'hFFFF_FFFC || s_fetch_addr_o !== 30'h3FFF_FFFF) begin errors++; $display("FAIL wrap_top got %h/%h want fffffffc/3fffffff", s_haddr_o, s_fetch_addr_o); end
        cyc(0, 0, 0, 0, 0, 1);
        checks++; if (s_haddr_o !== 32'h0 || s_valid_o !== 1'b1) begin errors++; $display("FAIL wrap_zero got %h/%b want 0/1", s_haddr_o, s_valid_o); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 4) == 0,
                ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                31'($urandom), $urandom_range(0, 3) != 0);
            checks++; if (s_haddr_o !== exp_haddr || s_htrans_o !== exp_htrans) begin errors++; $display("FAIL rnd_bus[%0d] got %h/%b want %h/%b", i, s_haddr_o, s_htrans_o, exp_haddr, exp_htrans); end
            checks++; if (s_valid_o !== exp_valid || s_ualign_o !== exp_ualign) begin errors++; $display("FAIL rnd_valid[%0d] got %b%b want %b%b", i, s_valid_o, s_ualign_o, exp_valid, exp_ualign); end
            if (exp_valid) begin
                checks++; if (s_fetch_addr_o !== exp_fetch) begin errors++; $display("FAIL rnd_fetch[%0d] got %h want %h", i, s_fetch_addr_o, exp_fetch); end
            end
            checks++; if (s_dvalid_o !== exp_dvalid) begin errors++; $display("FAIL rnd_dvalid[%0d] got %b want %b", i, s_dvalid_o, exp_dvalid); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sequential();
        test_hold();
        test_pop();
        test_flush_hold();
        test_flush_pop();
        test_ifb_full();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_addr_gen.md
Name: fetch_addr_gen

Overview:
- Fetch address generator directly upstream of the return address stack and the instruction fetch buffer (IFB).
- Issues word-aligned instruction fetches on the pipelined (AHB-lite style) instruction bus and chooses the next fetch address. Priority: flush redirect > RAS prediction > sequential increment.
- Produces the next-cycle valid, word address and unaligned flag consumed by the RAS.
- Marks returned bus data as usable or killed for the IFB.

Parameters:
BOOT_ADDR, 32'h0000_0080, first fetch address after reset (bit 0 ignored)

Ports:
s_clk_i  in  1  clock
s_resetn_i  in  1  reset; asynchronous, active-low
s_flush_i  in  1  pipeline flush/redirect request
s_flush_addr_i  in  32  flush target; bit 0 ignored
s_ifb_full_i  in  1  IFB cannot accept another outstanding word
s_poped_i  in  2  RAS prediction taken (from aligned/unaligned half)
s_pop_addr_i  in  31  RAS predicted target, halfword address [31:1]
s_hready_i  in  1  bus ready (ends address and data phase)
s_haddr_o  out  32  bus address, always word aligned
s_htrans_o  out  2  bus transfer type (IDLE/NONSEQ only)
s_valid_o  out  1  fetched data valid in next cycle (to RAS s_valid_i)
s_fetch_addr_o  out  30  word address of the data arriving next cycle
s_ualign_o  out  1  data arriving next cycle starts at upper halfword
s_dvalid_o  out  1  current bus read data are valid and not killed (IFB push)

Behaviour:
- Reset (async): state IDLE; address register = BOOT_ADDR[31:1]; s_haddr_o = {BOOT_ADDR[31:2],2'b00}; s_htrans_o = IDLE; s_valid_o = 0; s_ualign_o = 0; s_dvalid_o = 0; pending-data and kill flags cleared.
- Address register holds a halfword address A[31:1]. s_haddr_o = {A[31:2],2'b00}, driven from flops only; there is no combinational path from inputs to s_haddr_o or s_htrans_o.
- States:
  - IDLE: no transfer. Go to ISSUE the first cycle after reset release, or when s_ifb_full_i is low.
  - ISSUE: s_htrans_o = NONSEQ.
    - Accepted when s_hready_i = 1.
    - If accepted and s_ifb_full_i = 1, go to IDLE.
    - If not accepted (s_hready_i = 0), go to HOLD.
  - HOLD: address and NONSEQ held stable until s_hready_i = 1, then return to ISSUE or IDLE as above. A flush during HOLD does not change the bus address; it is stored in the redirect register instead.
- On acceptance in cycle t:
  - s_valid_o = 1, s_fetch_addr_o = A[31:2], s_ualign_o = A[1].
  - The pending flag is set for the data phase.
  - A ← next address. Unalign clears after a sequential step: next sequential = {A[31:2]+1, 0}.
- Next-address priority, evaluated on acceptance or in IDLE:
  1. s_flush_i (s_flush_addr_i[31:1]).
  2. Stored redirect.
  3. Valid s_poped_i != 0 (s_pop_addr_i).
  4. Sequential.
- Kill rules:
  - A prediction or flush arriving while a later sequential transfer is already accepted or outstanding sets that transfer's kill flag.
  - A flush also kills the current data phase.
- s_dvalid_o = pending & s_hready_i & ~kill & ~s_flush_i.
- s_poped_i is ignored when it coincides with s_flush_i (flush wins); the prediction is dropped and the RAS is not re-queried.
- s_valid_o is forced 0 in any cycle with s_flush_i = 1.
- Address wrap: 32'hFFFF_FFFC + 4 wraps to 0 silently.
- Reset asserted mid-transfer: all flags clear immediately; the next fetch is at BOOT_ADDR.
- At most one outstanding data phase; bus data phases are not reordered.

Decomposition:
- p_hardisc gains:
  - HTRANS_IDLE / HTRANS_NONSEQ constants.
  - Enum type f_fag_state {FAG_IDLE, FAG_ISSUE, FAG_HOLD}.
- Address, state and flag flops use seu_regs instances (GROUP 5), consistent with the other front-end blocks.
- No further sub-module; the next-address mux stays inline.

Test Plan:
- Reset release, hready = 1 → NONSEQ at 0x80, then 0x84, 0x88 in consecutive cycles; s_valid_o = 1 each cycle; s_fetch_addr_o = 0x20, 0x21, 0x22.
- hready low for 3 cycles on 0x84 → s_haddr_o stable at 0x84, state HOLD; s_valid_o asserted only in the cycle hready rises.
- s_poped_i = 2'b01, s_pop_addr_i = 31'h0000_0101 while 0x88 is in address phase → 0x88 data has s_dvalid_o = 0; next fetch is 0x200 with s_ualign_o = 1; following fetch is 0x204 with s_ualign_o = 0.
- s_flush_i with s_flush_addr_i = 0x1000 during HOLD → bus holds the old address until hready; that data is killed; next fetch is 0x1000.
- Flush and pop in the same cycle (flush 0x400, pop 0x800) → next fetch 0x400; pop ignored.
- s_ifb_full_i = 1 → htrans goes IDLE after the current acceptance; on release, fetch resumes at the next sequential address with no duplicate or skipped word.
